// File: rtl/ahb_sram_slave_if.sv
// Signal bundle between the AHB-Lite bus / byte-wide SRAM array and the SRAM slave front end.
interface ahb_sram_slave_if #(
  parameter int SRAM_DATA_WIDTH = 8,
  parameter int SRAM_ADDR_WIDTH = 13,
  parameter int DATA_WIDTH      = 32,
  parameter int ADDR_WIDTH      = 32
);
  logic                       hsel;
  logic [1:0]                 htrans;
  logic                       hwrite;
  logic [2:0]                 hsize;
  logic [2:0]                 hburst;
  logic [ADDR_WIDTH-1:0]      haddr;
  logic [DATA_WIDTH-1:0]      hwdata;
  logic                       hready_in;
  logic                       hready_resp;
  logic [1:0]                 hresp;
  logic [DATA_WIDTH-1:0]      hrdata;
  logic                       sram_we;
  logic [SRAM_ADDR_WIDTH-1:0] sram_addr;
  logic [DATA_WIDTH-1:0]      sram_wdata;
  logic [3:0]                 bank0_cs;
  logic [3:0]                 bank1_cs;
  logic [SRAM_DATA_WIDTH-1:0] sram_b0, sram_b1, sram_b2, sram_b3;
  logic [SRAM_DATA_WIDTH-1:0] sram_b4, sram_b5, sram_b6, sram_b7;

  modport slave (
    input  hsel, htrans, hwrite, hsize, hburst, haddr, hwdata, hready_in,
    input  sram_b0, sram_b1, sram_b2, sram_b3, sram_b4, sram_b5, sram_b6, sram_b7,
    output hready_resp, hresp, hrdata,
    output sram_we, sram_addr, sram_wdata, bank0_cs, bank1_cs
  );

  modport master (
    output hsel, htrans, hwrite, hsize, hburst, haddr, hwdata, hready_in,
    output sram_b0, sram_b1, sram_b2, sram_b3, sram_b4, sram_b5, sram_b6, sram_b7,
    input  hready_resp, hresp, hrdata,
    input  sram_we, sram_addr, sram_wdata, bank0_cs, bank1_cs
  );
endinterface

// File: rtl/ahb_sram_slave.sv
// AHB-Lite slave front end: turns AHB beats into byte-lane SRAM cycles across two banks.
module ahb_sram_slave #(
  parameter int SRAM_DATA_WIDTH = 8,
  parameter int SRAM_ADDR_WIDTH = 13,
  parameter int DATA_WIDTH      = 32,
  parameter int ADDR_WIDTH      = 32
) (
  input logic          hclk,
  input logic          hresetn,
  ahb_sram_slave_if.slave bus
);
  localparam int BANK_BIT = SRAM_ADDR_WIDTH + 2;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_READ   = 3'd1;
  localparam logic [2:0] S_WRITE  = 3'd2;
  localparam logic [2:0] S_WSTALL = 3'd3;
  localparam logic [2:0] S_ERR1   = 3'd4;
  localparam logic [2:0] S_ERR2   = 3'd5;

  logic [2:0]                 r_state;
  logic [SRAM_ADDR_WIDTH-1:0] r_addr;
  logic                       r_bank;
  logic [3:0]                 r_lanes;

  logic [2:0]                 w_state_next;
  logic                       w_valid;
  logic                       w_collide;
  logic                       w_ready;
  logic                       w_accept;
  logic                       w_illegal;
  logic                       w_bank;
  logic [3:0]                 w_lanes;
  logic [SRAM_ADDR_WIDTH-1:0] w_word;
  logic                       w_unused;

  assign w_valid   = bus.hsel & bus.htrans[1] & bus.hready_in;
  // A read arriving while the registered write owns the SRAM bus is held off one cycle.
  assign w_collide = (r_state == S_WRITE) & w_valid & ~bus.hwrite;
  assign w_ready   = (r_state != S_ERR1) & ~w_collide;
  assign w_accept  = hresetn & w_valid & w_ready;
  assign w_word    = bus.haddr[SRAM_ADDR_WIDTH+1:2];
  assign w_bank    = bus.haddr[BANK_BIT];
  assign w_unused  = ^{bus.hburst, bus.haddr[ADDR_WIDTH-1:BANK_BIT+1]};

  always_comb begin
    case (bus.hsize)
      3'd0:    w_illegal = 1'b0;
      3'd1:    w_illegal = bus.haddr[0];
      3'd2:    w_illegal = |bus.haddr[1:0];
      default: w_illegal = 1'b1;
    endcase
  end

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign w_lanes[gi] = (bus.hsize == 3'd2)
                         | ((bus.hsize == 3'd1) & (bus.haddr[1] == (gi >= 2)))
                         | ((bus.hsize == 3'd0) & (bus.haddr[1:0] == 2'(gi)));
    end
  endgenerate

  always_comb begin
    bus.sram_we   = 1'b0;
    bus.sram_addr = '0;
    bus.bank0_cs  = 4'b0000;
    bus.bank1_cs  = 4'b0000;
    if (hresetn) begin
      if (r_state == S_WRITE) begin
        bus.sram_we   = 1'b1;
        bus.sram_addr = r_addr;
        bus.bank0_cs  = r_bank ? 4'b0000 : r_lanes;
        bus.bank1_cs  = r_bank ? r_lanes : 4'b0000;
      end else if (w_accept & ~bus.hwrite & ~w_illegal) begin
        bus.sram_addr = w_word;
        bus.bank0_cs  = w_bank ? 4'b0000 : 4'b1111;
        bus.bank1_cs  = w_bank ? 4'b1111 : 4'b0000;
      end
    end
  end

  assign bus.sram_wdata  = bus.hwdata;
  assign bus.hready_resp = w_ready;
  assign bus.hresp       = ((r_state == S_ERR1) | (r_state == S_ERR2)) ? 2'b01 : 2'b00;
  assign bus.hrdata      = (r_state != S_READ) ? '0 :
                           r_bank ? {bus.sram_b7, bus.sram_b6, bus.sram_b5, bus.sram_b4}
                                  : {bus.sram_b3, bus.sram_b2, bus.sram_b1, bus.sram_b0};

  always_comb begin
    w_state_next = S_IDLE;
    if (w_accept) begin
      if (w_illegal)       w_state_next = S_ERR1;
      else if (bus.hwrite) w_state_next = S_WRITE;
      else                 w_state_next = S_READ;
    end else if (w_collide) begin
      w_state_next = S_WSTALL;
    end else if (r_state == S_ERR1) begin
      w_state_next = S_ERR2;
    end
  end

  always_ff @(posedge hclk) begin
    if (!hresetn) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_bank  <= 1'b0;
      r_lanes <= 4'b0000;
    end else begin
      r_state <= w_state_next;
      if (w_accept & ~w_illegal) begin
        r_addr  <= w_word;
        r_bank  <= w_bank;
        r_lanes <= w_lanes;
      end
    end
  end
endmodule

// File: tb/tb_ahb_sram_slave.sv
// Randomised bench for ahb_sram_slave against a byte-addressed memory model and AHB timing rules.
module tb_ahb_sram_slave;
  logic hclk = 1'b0;
  logic hresetn = 1'b0;
  always #5 hclk = ~hclk;

  ahb_sram_slave_if bus ();
  ahb_sram_slave dut (.hclk(hclk), .hresetn(hresetn), .bus(bus));

  logic [7:0] sram_mem [0:7][0:8191];
  logic [7:0] sram_q [0:7];
  logic [7:0] ref_mem [0:65535];

  int n_checks = 0;
  int n_errors = 0;
  bit prev_w = 1'b0, prev_r = 1'b0, rst_prev = 1'b0;
  int err_stage = 0;
  logic [15:0] pw_addr;
  logic [2:0]  pw_size;
  logic [31:0] pw_data;
  logic [31:0] exp_rdata;

  assign bus.sram_b0 = sram_q[0];
  assign bus.sram_b1 = sram_q[1];
  assign bus.sram_b2 = sram_q[2];
  assign bus.sram_b3 = sram_q[3];
  assign bus.sram_b4 = sram_q[4];
  assign bus.sram_b5 = sram_q[5];
  assign bus.sram_b6 = sram_q[6];
  assign bus.sram_b7 = sram_q[7];

  function automatic logic [7:0] pat(input logic [15:0] a);
    return (a[7:0] ^ a[15:8]) + 8'h3C;
  endfunction

  // Eight byte-wide SRAM macros: registered read, write on CS with we.
  initial begin : sram_model
    for (int a = 0; a < 65536; a++) sram_mem[(a >> 15) * 4 + (a & 3)][(a >> 2) & 8191] = pat(16'(a));
    for (int k = 0; k < 8; k++) sram_q[k] = 8'h00;
    forever begin
      @(posedge hclk);
      for (int k = 0; k < 8; k++) begin
        if ((k < 4) ? bus.bank0_cs[k % 4] : bus.bank1_cs[k % 4]) begin
          if (bus.sram_we) sram_mem[k][bus.sram_addr] <= bus.sram_wdata[8 * (k % 4) +: 8];
          else             sram_q[k] <= sram_mem[k][bus.sram_addr];
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%08h exp=%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit is_illegal(input logic [2:0] sz, input logic [15:0] a);
    if (sz > 3'd2) return 1'b1;
    return (int'(a) % (1 << sz)) != 0;
  endfunction

  function automatic logic [3:0] lane_mask(input logic [2:0] sz, input logic [15:0] a);
    logic [3:0] m = 4'b0000;
    for (int i = 0; i < (1 << sz); i++) m[(int'(a) + i) % 4] = 1'b1;
    return m;
  endfunction

  function automatic logic [31:0] ref_word(input logic [15:0] a);
    logic [31:0] w;
    for (int i = 0; i < 4; i++) w[8 * i +: 8] = ref_mem[(int'(a) & 32'hFFFC) + i];
    return w;
  endfunction

  // One bus cycle: drive the address phase (and pending write data), then check at negedge.
  task automatic cycle(input bit sel, input logic [1:0] tr, input bit wr, input logic [2:0] sz,
                       input logic [31:0] addr, input logic [31:0] wdata, input bit rstn,
                       output bit acc);
    bit valid, illegal, exp_ready;
    logic [15:0] a;
    logic [3:0] m;
    int lane;
    a = addr[15:0];
    @(posedge hclk);
    #1;
    hresetn       = rstn;
    bus.hsel      = sel;
    bus.htrans    = tr;
    bus.hwrite    = wr;
    bus.hsize     = sz;
    bus.haddr     = addr;
    bus.hburst    = 3'($urandom_range(0, 7));
    bus.hready_in = 1'b1;
    bus.hwdata    = prev_w ? pw_data : $urandom();
    @(negedge hclk);
    acc = 1'b0;
    if (!rstn) begin
      check("rst_we", 32'(bus.sram_we), 32'd0);
      check("rst_cs", 32'({bus.bank1_cs, bus.bank0_cs}), 32'd0);
      if (rst_prev) begin
        check("rst_ready", 32'(bus.hready_resp), 32'd1);
        check("rst_hresp", 32'(bus.hresp), 32'd0);
        check("rst_hrdata", bus.hrdata, 32'd0);
        check("rst_addr", 32'(bus.sram_addr), 32'd0);
      end
      prev_w = 1'b0;
      prev_r = 1'b0;
      err_stage = 0;
    end else begin
      valid     = sel && tr[1];
      illegal   = is_illegal(sz, a);
      exp_ready = (err_stage != 1) && !(prev_w && valid && !wr);
      check("hready", 32'(bus.hready_resp), 32'(exp_ready));
      check("hresp", 32'(bus.hresp), (err_stage != 0) ? 32'd1 : 32'd0);
      check("hrdata", bus.hrdata, prev_r ? exp_rdata : 32'd0);
      acc = valid && exp_ready;
      if (prev_w) begin
        m = lane_mask(pw_size, pw_addr);
        check("wr_we", 32'(bus.sram_we), 32'd1);
        check("wr_addr", 32'(bus.sram_addr), 32'(pw_addr[14:2]));
        check("wr_cs", 32'({bus.bank1_cs, bus.bank0_cs}), pw_addr[15] ? 32'({m, 4'h0}) : 32'(m));
        check("wr_wdata", bus.sram_wdata, pw_data);
        for (int i = 0; i < (1 << pw_size); i++) begin
          lane = (int'(pw_addr) + i) % 4;
          ref_mem[int'(pw_addr) + i] = pw_data[8 * lane +: 8];
        end
      end else if (acc && !wr && !illegal) begin
        check("rd_we", 32'(bus.sram_we), 32'd0);
        check("rd_addr", 32'(bus.sram_addr), 32'(a[14:2]));
        check("rd_cs", 32'({bus.bank1_cs, bus.bank0_cs}), a[15] ? 32'h0F0 : 32'h00F);
      end else begin
        check("idle_we", 32'(bus.sram_we), 32'd0);
        check("idle_cs", 32'({bus.bank1_cs, bus.bank0_cs}), 32'd0);
      end
      err_stage = (acc && illegal) ? 1 : ((err_stage == 1) ? 2 : 0);
      prev_w = acc && wr && !illegal;
      if (prev_w) begin
        pw_addr = a;
        pw_size = sz;
        pw_data = wdata;
      end
      prev_r = acc && !wr && !illegal;
      if (prev_r) exp_rdata = ref_word(a);
    end
    rst_prev = !rstn;
  endtask

  task automatic xfer(input bit wr, input logic [2:0] sz, input logic [31:0] addr,
                      input logic [31:0] wdata);
    bit acc = 1'b0;
    int tries = 0;
    while (!acc && tries < 8) begin
      cycle(1'b1, ($urandom_range(0, 1) != 0) ? 2'b11 : 2'b10, wr, sz, addr, wdata, 1'b1, acc);
      tries++;
    end
    if (!acc) check("xfer_timeout", 32'd0, 32'd1);
    $display("xfer %s addr=%08h size=%0d wdata=%08h waits=%0d", wr ? "WR" : "RD", addr, sz,
             wdata, tries - 1);
  endtask

  task automatic idle(input int n);
    bit acc;
    repeat (n) cycle(1'b0, 2'b00, 1'b0, 3'd0, 32'd0, 32'd0, 1'b1, acc);
  endtask

  task automatic rst_cycle();
    bit acc;
    cycle(1'b0, 2'b00, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0, acc);
    $display("xfer RST");
  endtask

  task automatic noacc(input bit sel, input logic [1:0] tr);
    bit acc;
    cycle(sel, tr, 1'b0, 3'd2, 32'h0000_0040, 32'd0, 1'b1, acc);
    $display("xfer NOP hsel=%0d htrans=%0d", sel, tr);
  endtask

  initial begin : main
    logic [15:0] a;
    logic [2:0] sz;
    int r;
    bus.hsel = 1'b0; bus.htrans = 2'b00; bus.hwrite = 1'b0; bus.hsize = 3'd0;
    bus.hburst = 3'd0; bus.haddr = 32'd0; bus.hwdata = 32'd0; bus.hready_in = 1'b1;
    for (int i = 0; i < 65536; i++) ref_mem[i] = pat(16'(i));

    rst_cycle();
    rst_cycle();

    xfer(1'b1, 3'd2, 32'h0000_0010, 32'hDEAD_BEEF);
    xfer(1'b0, 3'd2, 32'h0000_0010, 32'd0);
    idle(1);

    xfer(1'b1, 3'd0, 32'h0000_8003, 32'hAB00_0000 | ($urandom() & 32'h00FF_FFFF));
    xfer(1'b0, 3'd2, 32'h0000_8000, 32'd0);
    idle(1);

    for (int i = 0; i < 8; i++) xfer(1'b1, 3'd2, 32'(i * 4), $urandom());
    for (int i = 0; i < 8; i++) xfer(1'b0, 3'd2, 32'(i * 4), 32'd0);
    idle(1);

    xfer(1'b0, 3'd1, 32'h0000_0001, 32'd0);
    idle(3);
    xfer(1'b1, 3'd3, 32'h0000_0000, 32'h1111_2222);
    xfer(1'b0, 3'd2, 32'h0000_0000, 32'd0);
    idle(1);

    xfer(1'b1, 3'd2, 32'h0000_0200, 32'h1234_5678);
    rst_cycle();
    idle(1);
    xfer(1'b0, 3'd2, 32'h0000_0200, 32'd0);
    idle(1);

    xfer(1'b0, 3'd2, 32'h0000_0003, 32'd0);
    rst_cycle();
    idle(1);
    xfer(1'b0, 3'd2, 32'h0000_0204, 32'd0);
    idle(1);

    noacc(1'b1, 2'b00);
    noacc(1'b1, 2'b01);
    noacc(1'b0, 2'b10);
    noacc(1'b0, 2'b11);
    idle(1);

    for (int n = 0; n < 300; n++) begin
      r = $urandom_range(0, 99);
      if (r < 6) begin
        noacc(1'b1, 2'($urandom_range(0, 1)));
      end else if (r < 10) begin
        noacc(1'b0, 2'b10);
      end else if (r < 15) begin
        a  = 16'($urandom_range(0, 65535));
        sz = ($urandom_range(0, 1) != 0) ? 3'($urandom_range(3, 7)) : 3'd2;
        if (sz == 3'd2 && a[1:0] == 2'b00) a[0] = 1'b1;
        xfer($urandom_range(0, 1) != 0, sz, {16'($urandom()), a}, $urandom());
      end else begin
        sz = 3'($urandom_range(0, 2));
        a  = {1'($urandom_range(0, 1)), 8'h00, 7'($urandom_range(0, 127))};
        a  = a & ~16'((1 << sz) - 1);
        xfer($urandom_range(0, 1) != 0, sz, {16'($urandom()), a}, $urandom());
      end
    end
    idle(2);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
